// File: rtl/seq_mul_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package seq_mul_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int CNT_W     = $clog2(DEF_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_mul_step.sv
// One radix-2 shift-add iteration: conditionally add the multiplicand into the
// upper half of the accumulator, then shift {carry, acc} and the multiplier right.
module seq_mul_step
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   mcand,
    input  logic [WIDTH-1:0]   mplier,
    output logic [2*WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0]   mplier_next
);

    logic [WIDTH:0] sum_s;

    // Add in a (WIDTH+1)-bit adder so the carry survives into the shift.
    always_comb begin
        sum_s = {1'b0, acc[2*WIDTH-1:WIDTH]};
        if (mplier[0]) begin
            sum_s = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
        end else begin
            sum_s = {1'b0, acc[2*WIDTH-1:WIDTH]};
        end
        acc_next    = {sum_s, acc[WIDTH-1:1]};
        mplier_next = {1'b0, mplier[WIDTH-1:1]};
    end

endmodule

// File: rtl/seq_mul32.sv
// Sequential radix-2 shift-add multiplier with start/done handshake.
// Optional signed mode is enabled by defining SEQ_MUL_SIGNED_EN.
module seq_mul32
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               n_rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   src1,
    input  logic [WIDTH-1:0]   src2,
`ifdef SEQ_MUL_SIGNED_EN
    input  logic               signed_op,
`endif
    output logic [2*WIDTH-1:0] prod,
    output logic               done,
    output logic               busy
);

    localparam int IT_W = $clog2(WIDTH + 1);
    localparam logic [IT_W-1:0] LAST_IT = IT_W'(WIDTH - 1);

    state_e               state_r, state_s;
    logic [2*WIDTH-1:0]   acc_r, acc_step_s, result_s;
    logic [WIDTH-1:0]     mcand_r, mplier_r, mplier_step_s;
    logic [WIDTH-1:0]     op1_s, op2_s;
    logic [IT_W-1:0]      cnt_r;
    logic [2*WIDTH-1:0]   prod_r;
    logic                 done_r, busy_r;
`ifdef SEQ_MUL_SIGNED_EN
    logic                 sign_r, sign_s;
`endif

    assign prod = prod_r;
    assign done = done_r;
    assign busy = busy_r;

    seq_mul_step #(.WIDTH(WIDTH)) u_step (
        .acc         (acc_r),
        .mcand       (mcand_r),
        .mplier      (mplier_r),
        .acc_next    (acc_step_s),
        .mplier_next (mplier_step_s)
    );

    // Operand preparation at acceptance: magnitudes and product sign in signed mode.
    always_comb begin
        op1_s = src1;
        op2_s = src2;
`ifdef SEQ_MUL_SIGNED_EN
        sign_s = 1'b0;
        if (signed_op) begin
            if (src1[WIDTH-1]) begin
                op1_s = ~src1 + WIDTH'(1);
            end else begin
                op1_s = src1;
            end
            if (src2[WIDTH-1]) begin
                op2_s = ~src2 + WIDTH'(1);
            end else begin
                op2_s = src2;
            end
            sign_s = src1[WIDTH-1] ^ src2[WIDTH-1];
        end else begin
            sign_s = 1'b0;
        end
`endif
    end

    // Final product: negate the magnitude when the latched sign says so.
    always_comb begin
        result_s = acc_r;
`ifdef SEQ_MUL_SIGNED_EN
        if (sign_r) begin
            result_s = ~acc_r + (2*WIDTH)'(1);
        end else begin
            result_s = acc_r;
        end
`endif
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; DONE lasts two cycles: result write, then the done pulse.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = RUN;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (cnt_r == LAST_IT) begin
                    state_s = DONE;
                end else begin
                    state_s = RUN;
                end
            end
            DONE: begin
                if (done_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Datapath and handshake registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            acc_r    <= '0;
            mcand_r  <= '0;
            mplier_r <= '0;
            cnt_r    <= '0;
            prod_r   <= '0;
            done_r   <= 1'b0;
            busy_r   <= 1'b0;
`ifdef SEQ_MUL_SIGNED_EN
            sign_r   <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        acc_r    <= '0;
                        cnt_r    <= '0;
                        mcand_r  <= op1_s;
                        mplier_r <= op2_s;
                        busy_r   <= 1'b1;
`ifdef SEQ_MUL_SIGNED_EN
                        sign_r   <= sign_s;
`endif
                    end
                end
                RUN: begin
                    acc_r    <= acc_step_s;
                    mplier_r <= mplier_step_s;
                    cnt_r    <= cnt_r + IT_W'(1);
                end
                DONE: begin
                    if (!done_r) begin
                        prod_r <= result_s;
                        done_r <= 1'b1;
                    end else begin
                        done_r <= 1'b0;
                        busy_r <= 1'b0;
                    end
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul32.sv
// Self-checking bench for seq_mul32 with a plain-arithmetic reference model.
// Signed scenarios run when SEQ_MUL_SIGNED_EN is defined.
module tb_seq_mul32;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        start = 1'b0;
    logic [31:0] src1 = 32'd0;
    logic [31:0] src2 = 32'd0;
`ifdef SEQ_MUL_SIGNED_EN
    logic        signed_op = 1'b0;
`endif
    logic [63:0] prod;
    logic        done;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    seq_mul32 dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .start     (start),
        .src1      (src1),
        .src2      (src2),
`ifdef SEQ_MUL_SIGNED_EN
        .signed_op (signed_op),
`endif
        .prod      (prod),
        .done      (done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            return 64'(sa * sb);
        end else begin
            return {32'd0, a} * {32'd0, b};
        end
    endfunction

    // Issue one operation, wait for done (bounded), step past the done cycle.
    // lat = edges from the accepting edge to done (-1 on timeout);
    // post_ok = done dropped, busy dropped and prod held one cycle later.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [63:0] p, output int lat, output logic post_ok);
        @(negedge clk);
        start = 1'b1;
        src1  = a;
        src2  = b;
`ifdef SEQ_MUL_SIGNED_EN
        signed_op = s;
`endif
        @(posedge clk);
        #1;
        start = 1'b0;
        src1  = $urandom;
        src2  = $urandom;
`ifdef SEQ_MUL_SIGNED_EN
        signed_op = $urandom_range(0, 1) == 1;
`endif
        lat = 0;
        p   = 64'd0;
        while (lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
            if (done) break;
        end
        if (!done) begin
            lat = -1;
        end else begin
            p = prod;
        end
        @(posedge clk);
        #1;
        post_ok = !done && !busy && (prod === p);
    endtask

    task automatic test_reset();
        #12;
        n_checks++; if (prod !== 64'd0) begin n_fail++; $display("FAIL reset_prod got=%h exp=0", prod); end
        n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_limits();
        logic [63:0] p; int lat; logic ok;
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, p, lat, ok);
        n_checks++; if (p !== 64'hFFFF_FFFE_0000_0001) begin n_fail++; $display("FAIL limits_prod got=%h exp=fffffffe00000001", p); end
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL limits_latency got=%0d exp=33", lat); end
        n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL limits_post got=%b exp=1", ok); end
    endtask

    task automatic test_zero_identity();
        logic [63:0] p; int lat; logic ok;
        do_op(32'd0, 32'h1234_5678, 1'b0, p, lat, ok);
        n_checks++; if (p !== 64'd0) begin n_fail++; $display("FAIL zero_prod got=%h exp=0", p); end
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL zero_latency got=%0d exp=33", lat); end
        do_op(32'h1234_5678, 32'd1, 1'b0, p, lat, ok);
        n_checks++; if (p !== 64'h0000_0000_1234_5678) begin n_fail++; $display("FAIL identity_prod got=%h exp=12345678", p); end
    endtask

    task automatic test_busy_ignore();
        int ndone; logic [63:0] p;
        @(negedge clk);
        start = 1'b1; src1 = 32'd7; src2 = 32'd6;
        @(posedge clk);
        #1;
        start = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL busy_after_start got=%b exp=1", busy); end
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; src1 = 32'd9; src2 = 32'd9;
        @(posedge clk);
        #1;
        start = 1'b0;
        ndone = 0;
        p = 64'd0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #1;
            if (done) begin ndone++; p = prod; end
        end
        n_checks++; if (ndone !== 1) begin n_fail++; $display("FAIL busy_ignore_dones got=%0d exp=1", ndone); end
        n_checks++; if (p !== 64'd42) begin n_fail++; $display("FAIL busy_ignore_prod got=%0d exp=42", p); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_ignore_idle got=%b exp=0", busy); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] p; int lat; logic ok;
        do_op(32'd3, 32'd5, 1'b0, p, lat, ok);
        n_checks++; if (p !== 64'd15) begin n_fail++; $display("FAIL b2b_first got=%0d exp=15", p); end
        do_op(32'h0001_0000, 32'h0001_0000, 1'b0, p, lat, ok);
        n_checks++; if (p !== 64'h0000_0001_0000_0000) begin n_fail++; $display("FAIL b2b_second got=%h exp=100000000", p); end
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=33", lat); end
    endtask

    task automatic test_reset_mid_op();
        logic [63:0] p; int lat; logic ok; int ndone;
        @(negedge clk);
        start = 1'b1; src1 = 32'h0000_DEAD; src2 = 32'h0000_BEEF;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        n_rst = 1'b0;
        #1;
        n_checks++; if (prod !== 64'd0) begin n_fail++; $display("FAIL midrst_prod got=%h exp=0", prod); end
        n_checks++; if (done !== 1'b0)  begin n_fail++; $display("FAIL midrst_done got=%b exp=0", done); end
        n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        n_checks++; if (ndone !== 0) begin n_fail++; $display("FAIL midrst_no_resume got=%0d exp=0", ndone); end
        do_op(32'd2, 32'd3, 1'b0, p, lat, ok);
        n_checks++; if (p !== 64'd6) begin n_fail++; $display("FAIL midrst_after got=%0d exp=6", p); end
    endtask

`ifdef SEQ_MUL_SIGNED_EN
    task automatic test_signed();
        logic [63:0] p; int lat; logic ok;
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, p, lat, ok);
        n_checks++; if (p !== 64'd1) begin n_fail++; $display("FAIL signed_m1m1 got=%h exp=1", p); end
        n_checks++; if (lat !== 33) begin n_fail++; $display("FAIL signed_latency got=%0d exp=33", lat); end
        do_op(32'hFFFF_FFFE, 32'd3, 1'b1, p, lat, ok);
        n_checks++; if (p !== 64'hFFFF_FFFF_FFFF_FFFA) begin n_fail++; $display("FAIL signed_m2x3 got=%h exp=fffffffffffffffa", p); end
    endtask
`endif

    task automatic test_random();
        logic [63:0] p, exp_p; int lat; logic ok;
        logic [31:0] a, b; logic s;
        for (int i = 0; i < 499; i++) begin
            case ($urandom_range(0, 7))
                0:       a = 32'd0;
                1:       a = 32'hFFFF_FFFF;
                2:       a = 32'h8000_0000;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = 32'd1;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'h8000_0000;
                default: b = $urandom;
            endcase
`ifdef SEQ_MUL_SIGNED_EN
            s = $urandom_range(0, 1) == 1;
`else
            s = 1'b0;
`endif
            exp_p = ref_mul(a, b, s);
            do_op(a, b, s, p, lat, ok);
            n_checks++;
            if (p !== exp_p || lat !== 33 || ok !== 1'b1) begin
                n_fail++;
                $display("FAIL random[%0d] a=%h b=%h s=%b got=%h lat=%0d post=%b exp=%h lat=33 post=1",
                         i, a, b, s, p, lat, ok, exp_p);
            end
        end
    endtask

    initial begin
        test_reset();
        test_limits();
        test_zero_identity();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid_op();
`ifdef SEQ_MUL_SIGNED_EN
        test_signed();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
